// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one synchronous FIFO write port
// among N_REQ producers. The grant is combinational, so a producer's word is
// pushed in the same cycle it is offered and selected.
//
// Optional feature: define FIFO_ARB_BURST_EN to let the most recent producer
// keep the port for up to MAX_BURST consecutive pushes before rotating.
// Without the macro, the grant rotates after every push.
module fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int W_SRC     = $clog2(N_REQ),
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_w_en,
    output logic [WIDTH-1:0]       fifo_w_data,
    output logic [W_SRC-1:0]       fifo_w_src,
    input  logic                   fifo_full,
    output logic [W_SRC-1:0]       last_grant,
    output logic [15:0]            push_count
);

    // (base + k) mod N_REQ, valid for base < N_REQ and 1 <= k <= N_REQ
    function automatic logic [W_SRC-1:0] wrap_add(input logic [W_SRC-1:0] base,
                                                  input int unsigned    k);
        int unsigned s;
        s = int'(base) + k;
        if (s >= N_REQ)
            s = s - N_REQ;
        return s[W_SRC-1:0];
    endfunction

    logic             rr_found_p0;
    logic [W_SRC-1:0] rr_idx_p0;
    logic             hold_p0;
    logic             grant_vld_p0;
    logic [W_SRC-1:0] grant_idx_p0;

`ifdef FIFO_ARB_BURST_EN
    logic [7:0] burst_cnt;
    // Set by the first push after reset so that the reset value of last_grant
    // is never treated as a burst holder; producer 0 still goes first.
    logic       burst_act;
`endif

    // Round-robin search starting just after last_grant; last_grant comes last
    always_comb begin
        rr_found_p0 = 1'b0;
        rr_idx_p0   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!rr_found_p0 && req_valid[wrap_add(last_grant, k)]) begin
                rr_found_p0 = 1'b1;
                rr_idx_p0   = wrap_add(last_grant, k);
            end
        end
    end

    // Burst hold takes priority over the rotation while the holder has budget
    always_comb begin
`ifdef FIFO_ARB_BURST_EN
        hold_p0 = burst_act && req_valid[last_grant] &&
                  (burst_cnt < 8'(MAX_BURST - 1));
`else
        hold_p0 = 1'b0;
`endif
        grant_vld_p0 = rst_n && !fifo_full && (hold_p0 || rr_found_p0);
        grant_idx_p0 = hold_p0 ? last_grant : rr_idx_p0;
    end

    // Steer the granted producer onto the write port; all zero when no grant
    always_comb begin
        req_ready   = '0;
        fifo_w_en   = grant_vld_p0;
        fifo_w_data = '0;
        fifo_w_src  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_vld_p0 && (grant_idx_p0 == W_SRC'(i))) begin
                req_ready[i] = 1'b1;
                fifo_w_data  = req_data[i*WIDTH +: WIDTH];
                fifo_w_src   = W_SRC'(i);
            end
        end
    end

    // Arbitration state: last winner, push counter and burst bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= W_SRC'(N_REQ - 1);
            push_count <= 16'd0;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt  <= 8'd0;
            burst_act  <= 1'b0;
`endif
        end else if (grant_vld_p0) begin
            last_grant <= grant_idx_p0;
            push_count <= push_count + 16'd1;
`ifdef FIFO_ARB_BURST_EN
            burst_act  <= 1'b1;
            if (hold_p0)
                burst_cnt <= burst_cnt + 8'd1;
            else
                burst_cnt <= 8'd0;
`endif
        end
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of producers sharing one sync FIFO write port (legal range 2..16).
REQ-002 Parameter WIDTH, default 32, payload width per producer.
REQ-003 Parameter W_SRC, default $clog2(N_REQ), width of the source-index fields.
REQ-004 Parameter MAX_BURST, default 4, maximum consecutive grants to one producer when FIFO_ARB_BURST_EN is defined (legal range 1..255).
REQ-005 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 req_valid  input  N_REQ  bit i: producer i offers a word.
REQ-009 req_data  input  N_REQ*WIDTH  producer i payload at [i*WIDTH +: WIDTH].
REQ-010 req_ready  output  N_REQ  bit i: producer i's word is accepted this cycle; at most one bit set.
REQ-011 fifo_w_en  output  1  push strobe to the FIFO.
REQ-012 fifo_w_data  output  WIDTH  payload pushed.
REQ-013 fifo_w_src  output  W_SRC  index of the producer pushed.
REQ-014 fifo_full  input  1  FIFO full flag.
REQ-015 last_grant  output  W_SRC  registered index of the most recently granted producer.
REQ-016 push_count  output  16  registered total push counter.

Function
REQ-017 A transfer on producer i SHALL occur iff req_valid[i] && req_ready[i] in the same cycle; each transfer SHALL assert fifo_w_en in that same cycle, giving zero latency.
REQ-018 When fifo_full=1 or rst_n=0: req_ready=0, fifo_w_en=0, fifo_w_data=0, fifo_w_src=0. A same-cycle FIFO pop SHALL NOT unblock the push.
REQ-019 Otherwise the grant SHALL be the first i with req_valid[i]=1, searching (last_grant+1) mod N_REQ upward with wrap-around; last_grant itself SHALL be searched last.
REQ-020 If no req_valid bit is set, there SHALL be no grant, fifo_w_en=0, and fifo_w_data/fifo_w_src=0.
REQ-021 On a grant: req_ready[g]=1, fifo_w_en=1, fifo_w_data=req_data slice g, fifo_w_src=g.
REQ-022 After each push, last_grant SHALL become g on the next edge; with no push it SHALL hold.
REQ-023 req_ready SHALL never assert for a producer whose req_valid=0.
REQ-024 push_count SHALL increment by 1 on each push and wrap from 0xFFFF to 0x0000.
REQ-025 The grant SHALL be purely combinational from req_valid, fifo_full, rst_n and registered state, with no dependency on req_data.

Reset
REQ-026 While rst_n=0 at a rising edge: last_grant <= N_REQ-1, burst counter <= 0, push_count <= 0, so producer 0 has first priority after reset.
REQ-027 Reset asserted mid-stream SHALL suppress any push in that cycle per REQ-018; no partial state SHALL survive.

Configuration
REQ-028 Macro FIFO_ARB_BURST_EN.
- Defined: the block keeps an 8-bit burst counter.
  - If req_valid[last_grant]=1 and burst count < MAX_BURST-1, last_grant SHALL be re-granted ahead of the round-robin search; each re-grant increments the counter.
  - A grant to a different producer resets the counter to 0.
  - A stall (fifo_full) or an idle cycle holds the counter.
  - If the holder drops req_valid, round-robin resumes from last_grant+1.
- Undefined: no burst counter exists, and the grant rotates after every push per REQ-019.

Verification (N_REQ=4, WIDTH=32, MAX_BURST=4)
REQ-029 Reset then req_valid=4'b1111, fifo_full=0 for 8 cycles, without the macro -> fifo_w_src sequence 0,1,2,3,0,1,2,3 and push_count=8.
REQ-030 Same stimulus with FIFO_ARB_BURST_EN -> fifo_w_src sequence 0,0,0,0,1,1,1,1.
REQ-031 last_grant=3, req_valid=4'b1001 -> grant 0; next cycle -> grant 3; this checks the wrap-around.
REQ-032 req_valid=4'b0100 with fifo_full=1 for 3 cycles, then 0 -> no fifo_w_en or req_ready for 3 cycles, grant 2 on the 4th cycle, and last_grant holds during the stall.
REQ-033 rst_n driven low for 1 cycle mid-stream with req_valid=4'b1111 -> no push that cycle; after reset, first grant 0 and push_count=0.
REQ-034 push_count=0xFFFF followed by one push -> push_count=0x0000.
